// File: rtl/strength_resolve_rx.sv
// strength_resolve_rx: serial resolver for a strength-tagged multi-driver net with expected-value check
// Ports: clk/rst (sync, active-high); in_valid/in_ready snapshot handshake carrying
//   drv_val (2b/driver, 00=0 01=1 10=x 11=z), drv_str0/drv_str1 (3b/driver), exp_val;
//   out_valid/out_ready result handshake carrying res_val, res_str, mismatch; err_cnt saturating.
// Optional macro STRENGTH_RX_STICKY_EN: mismatch stays set until rst.
module strength_resolve_rx #(
    parameter int N_DRV = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N_DRV-1:0] drv_val,
    input  logic [3*N_DRV-1:0] drv_str0,
    input  logic [3*N_DRV-1:0] drv_str1,
    input  logic [1:0]         exp_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         res_val,
    output logic [2:0]         res_str,
    output logic               mismatch,
    output logic [CNT_W-1:0]   err_cnt
);
    localparam int IW = $clog2(N_DRV + 1);
    typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0]      idx;
    logic [2*N_DRV-1:0] val_q;
    logic [3*N_DRV-1:0] s0_q, s1_q;
    logic [1:0]         exp_q, acc_val, dv;
    logic [2:0]         acc_str, d0, d1, ds;
    logic               last, bad;
    always_comb begin
        dv   = 2'(val_q >> (2 * idx));
        d0   = 3'(s0_q >> (3 * idx));
        d1   = 3'(s1_q >> (3 * idx));
        ds   = dv == 2'b00 ? d0 : dv == 2'b01 ? d1 : dv == 2'b10 ? (d0 > d1 ? d0 : d1) : 3'd0;
        last = idx == IW'(N_DRV);
        bad  = acc_val != exp_q;
    end
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE && !rst;
        out_valid = state == DONE;
        case (state)
            IDLE:    state_nx = in_valid ? RESOLVE : IDLE;
            RESOLVE: state_nx = last ? DONE : RESOLVE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            acc_val  <= 2'b11;
            acc_str  <= 3'd0;
            res_val  <= 2'b11;
            res_str  <= 3'd0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            val_q    <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            exp_q    <= 2'b11;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                val_q   <= drv_val;
                s0_q    <= drv_str0;
                s1_q    <= drv_str1;
                exp_q   <= exp_val;
                acc_val <= 2'b11;
                acc_str <= 3'd0;
                idx     <= '0;
            end
            // idx == N_DRV is a finalize step that publishes the accumulator
            if (state == RESOLVE && last) begin
                res_val <= acc_val;
                res_str <= acc_str;
`ifdef STRENGTH_RX_STICKY_EN
                mismatch <= mismatch | bad;
`else
                mismatch <= bad;
`endif
                if (bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else if (state == RESOLVE) begin
                idx <= idx + 1'b1;
                if (ds > acc_str) begin
                    acc_val <= dv;
                    acc_str <= ds;
                end else if (ds == acc_str && ds != 3'd0 && dv != acc_val) begin
                    acc_val <= 2'b10;
                end
            end
`ifndef STRENGTH_RX_STICKY_EN
            if (state == DONE && out_ready) mismatch <= 1'b0;
`endif
        end
    end
endmodule
